// File: rtl/div_core_arbiter.sv
// Round-robin owner of one shared div_core: grants one requester at a time, holds
// ownership until div_done, then returns the registered result with a done pulse.
// state | meaning
// IDLE  | arbitrating; a grant issues div_start in the same cycle
// BUSY  | divider working for owner_q; div_done delivers the result
// DRAIN | flushed operation still in the divider; wait for div_done, discard it
module div_core_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CLZ_W      = $clog2(DATA_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor_i,
  input  logic [NUM_REQ*CLZ_W-1:0]      req_dividend_clz_i,
  input  logic [NUM_REQ*CLZ_W-1:0]      req_divisor_clz_i,
  input  logic [NUM_REQ-1:0]            req_divisor_is_zero_i,
  output logic [NUM_REQ-1:0]            req_grant_o,
  output logic [NUM_REQ-1:0]            req_done_o,
  output logic [DATA_WIDTH-1:0]         res_quotient_o,
  output logic [DATA_WIDTH-1:0]         res_remainder_o,
  output logic                          busy_o,
  output logic                          div_start_o,
  output logic [DATA_WIDTH-1:0]         div_dividend_o,
  output logic [DATA_WIDTH-1:0]         div_divisor_o,
  output logic [CLZ_W-1:0]              div_dividend_clz_o,
  output logic [CLZ_W-1:0]              div_divisor_clz_o,
  output logic                          div_divisor_is_zero_o,
  input  logic                          div_done_i,
  input  logic [DATA_WIDTH-1:0]         div_quotient_i,
  input  logic [DATA_WIDTH-1:0]         div_remainder_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;

  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      sel_idx;
  logic                  gnt_found;
  logic                  gnt_fire;

  // Scan from the far end so the candidate closest to rr_ptr_q is written last and wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_fire    = (state_q == S_IDLE) && !flush_i && gnt_found;
  assign sel_idx     = gnt_fire ? gnt_idx : rr_ptr_q;
  assign req_grant_o = gnt_fire ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign div_start_o = gnt_fire;

  assign div_dividend_o        = req_dividend_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign div_divisor_o         = req_divisor_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign div_dividend_clz_o    = req_dividend_clz_i[int'(sel_idx)*CLZ_W +: CLZ_W];
  assign div_divisor_clz_o     = req_divisor_clz_i[int'(sel_idx)*CLZ_W +: CLZ_W];
  assign div_divisor_is_zero_o = req_divisor_is_zero_i[sel_idx];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    done_d   = '0;
    quo_d    = quo_q;
    rem_d    = rem_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_fire) begin
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (div_done_i) begin
          state_d = S_IDLE;
          // A flush landing with done discards the result like a drain would.
          if (!flush_i) begin
            quo_d  = div_quotient_i;
            rem_d  = div_remainder_i;
            done_d = NUM_REQ'(1) << owner_q;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      done_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  assign req_done_o      = done_q;
  assign res_quotient_o  = quo_q;
  assign res_remainder_o = rem_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_core_arbiter.sv
// Scoreboard bench for div_core_arbiter: a behavioural divider answers div_start
// after a programmable latency; a monitor checks every grant and done against queues.
module tb_div_core_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_dividend, req_divisor;
  logic [NR*CW-1:0] req_dividend_clz, req_divisor_clz;
  logic [NR-1:0]   req_divisor_is_zero;
  logic [NR-1:0]   req_grant, req_done;
  logic [DW-1:0]   res_quotient, res_remainder;
  logic            busy, div_start;
  logic [DW-1:0]   div_dividend, div_divisor;
  logic [CW-1:0]   div_dividend_clz, div_divisor_clz;
  logic            div_divisor_is_zero;
  logic            div_done;
  logic [DW-1:0]   div_quotient, div_remainder;

  div_core_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CLZ_W(CW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_i               (flush),
    .req_valid_i           (req_valid),
    .req_dividend_i        (req_dividend),
    .req_divisor_i         (req_divisor),
    .req_dividend_clz_i    (req_dividend_clz),
    .req_divisor_clz_i     (req_divisor_clz),
    .req_divisor_is_zero_i (req_divisor_is_zero),
    .req_grant_o           (req_grant),
    .req_done_o            (req_done),
    .res_quotient_o        (res_quotient),
    .res_remainder_o       (res_remainder),
    .busy_o                (busy),
    .div_start_o           (div_start),
    .div_dividend_o        (div_dividend),
    .div_divisor_o         (div_divisor),
    .div_dividend_clz_o    (div_dividend_clz),
    .div_divisor_clz_o     (div_divisor_clz),
    .div_divisor_is_zero_o (div_divisor_is_zero),
    .div_done_i            (div_done),
    .div_quotient_i        (div_quotient),
    .div_remainder_i       (div_remainder)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } done_t;

  int    exp_grant[$];
  done_t exp_done[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    lat   = 4;
  int    spur_req = 0;
  int    tg;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_dividend[i*DW +: DW] = a;
    req_divisor[i*DW +: DW]  = b;
    req_divisor_is_zero[i]   = (b == '0);
  endtask

  task automatic wait_grant(input int idx, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_grant[idx]) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, {63'd0, got}, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, {63'd0, got}, 64'd1);
  endtask

  // Behavioural divider: samples start at negedge, answers exactly lat cycles later.
  initial begin
    int cnt = 0;
    int spur_ack = 0;
    logic [DW-1:0] a, b;
    logic z;
    div_done = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    a = '0; b = '0; z = 1'b0;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done      = 1'b1;
          div_quotient  = z ? '1 : a / b;
          div_remainder = z ? a : a % b;
        end
      end
      if (spur_req != spur_ack) begin
        spur_ack      = spur_req;
        div_done      = 1'b1;
        div_quotient  = 32'h1234_5678;
        div_remainder = 32'h0000_9abc;
      end
      if (div_start && !rst) begin
        a   = div_dividend;
        b   = div_divisor;
        z   = div_divisor_is_zero;
        cnt = lat;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (div_start || (req_grant != '0))
          chk("start_vs_grant", {63'd0, div_start}, {63'd0, (req_grant != '0)});
        if (req_grant != '0) begin
          if (exp_grant.size() == 0) begin
            chk("unexpected_grant", {62'd0, req_grant}, 64'd0);
          end else begin
            int g;
            logic [NR-1:0] oh;
            g  = exp_grant.pop_front();
            oh = NR'(1) << g;
            chk("grant_vec", {62'd0, req_grant}, {62'd0, oh});
          end
        end
        if (req_done != '0) begin
          if (exp_done.size() == 0) begin
            chk("unexpected_done", {62'd0, req_done}, 64'd0);
          end else begin
            done_t e;
            logic [NR-1:0] oh;
            e  = exp_done.pop_front();
            oh = NR'(1) << e.idx;
            chk("done_vec", {62'd0, req_done}, {62'd0, oh});
            chk("done_quo", {32'd0, res_quotient}, {32'd0, e.q});
            chk("done_rem", {32'd0, res_remainder}, {32'd0, e.r});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    req_dividend_clz = '0;
    req_divisor_clz = '0;
    req_divisor_is_zero = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", {62'd0, req_grant}, 64'd0);
    chk("rst_done", {62'd0, req_done}, 64'd0);
    chk("rst_start", {63'd0, div_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_quo", {32'd0, res_quotient}, 64'd0);
    chk("rst_rem", {32'd0, res_remainder}, 64'd0);

    // single request, latency 4
    @(posedge clk); #1;
    set_op(0, 100, 7);
    req_dividend_clz[4:0] = 5'd25;
    req_divisor_clz[4:0]  = 5'd29;
    exp_grant.push_back(0);
    exp_done.push_back('{0, 32'd14, 32'd2});
    req_valid = 2'b01;
    wait_grant(0, "t1_grant");
    tg = cyc;
    chk("t1_start", {63'd0, div_start}, 64'd1);
    chk("t1_dvd", {32'd0, div_dividend}, 64'd100);
    chk("t1_dvs", {32'd0, div_divisor}, 64'd7);
    chk("t1_dvd_clz", {59'd0, div_dividend_clz}, 64'd25);
    chk("t1_dvs_clz", {59'd0, div_divisor_clz}, 64'd29);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t1_idle");
    chk("t1_latency", 64'(cyc - tg), 64'd5);
    chk("t1_quo", {32'd0, res_quotient}, 64'd14);
    chk("t1_rem", {32'd0, res_remainder}, 64'd2);
    req_dividend_clz = '0;
    req_divisor_clz = '0;

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // contention, both requesters always valid
    set_op(0, 50, 5);
    set_op(1, 9, 4);
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back(k % 2);
      if (k % 2 == 0) exp_done.push_back('{0, 32'd10, 32'd0});
      else            exp_done.push_back('{1, 32'd2, 32'd1});
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) wait_grant(k % 2, "t2_grant");
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t2_idle");
    chk("t2_quo", {32'd0, res_quotient}, 64'd2);
    chk("t2_rem", {32'd0, res_remainder}, 64'd1);

    // flush in BUSY, pending req0 waits for the drained div_done
    lat = 6;
    @(posedge clk); #1;
    set_op(1, 1000, 3);
    exp_grant.push_back(1);
    req_valid = 2'b10;
    wait_grant(1, "t3_grant1");
    tg = cyc;
    chk("t3_dvd", {32'd0, div_dividend}, 64'd1000);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    flush = 1'b1;
    set_op(0, 50, 5);
    exp_grant.push_back(0);
    exp_done.push_back('{0, 32'd10, 32'd0});
    req_valid = 2'b01;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t3_drain_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_grant(0, "t3_grant0");
    chk("t3_grant_gap", 64'(cyc - tg), 64'd7);
    chk("t3_quo_hold", {32'd0, res_quotient}, 64'd2);
    chk("t3_rem_hold", {32'd0, res_remainder}, 64'd1);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t3_idle");
    chk("t3_quo", {32'd0, res_quotient}, 64'd10);

    // flush coincident with div_done, then flush in IDLE blocks a grant
    lat = 3;
    @(posedge clk); #1;
    set_op(0, 7, 2);
    exp_grant.push_back(0);
    req_valid = 2'b01;
    wait_grant(0, "t4_grant");
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_quo_hold", {32'd0, res_quotient}, 64'd10);
    chk("t4_rem_hold", {32'd0, res_remainder}, 64'd0);
    @(posedge clk); #1;
    set_op(1, 9, 4);
    req_valid = 2'b10;
    flush = 1'b1;
    @(negedge clk);
    chk("t4_idle_flush_grant", {62'd0, req_grant}, 64'd0);
    chk("t4_idle_flush_start", {63'd0, div_start}, 64'd0);
    exp_grant.push_back(1);
    exp_done.push_back('{1, 32'd2, 32'd1});
    @(posedge clk); #1 flush = 1'b0;
    wait_grant(1, "t4_grant1");
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t4_idle");

    // divide by zero
    lat = 4;
    @(posedge clk); #1;
    set_op(0, 32'hDEAD_BEEF, 0);
    exp_grant.push_back(0);
    exp_done.push_back('{0, 32'hFFFF_FFFF, 32'hDEAD_BEEF});
    req_valid = 2'b01;
    wait_grant(0, "t5_grant");
    chk("t5_is_zero", {63'd0, div_divisor_is_zero}, 64'd1);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t5_idle");

    // rst in BUSY, spurious div_done in IDLE, rr pointer back at 0
    lat = 8;
    @(posedge clk); #1;
    set_op(0, 100, 7);
    exp_grant.push_back(0);
    req_valid = 2'b01;
    wait_grant(0, "t6_grant");
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_quo", {32'd0, res_quotient}, 64'd0);
    chk("t6_rem", {32'd0, res_remainder}, 64'd0);
    @(posedge clk); #1 spur_req++;
    repeat (3) @(negedge clk);
    chk("t6_spur_quo", {32'd0, res_quotient}, 64'd0);
    chk("t6_spur_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    set_op(0, 50, 5);
    set_op(1, 9, 4);
    exp_grant.push_back(0);
    exp_done.push_back('{0, 32'd10, 32'd0});
    req_valid = 2'b11;
    wait_grant(0, "t6_rr_reset");
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t6_idle");

    repeat (5) @(negedge clk);
    chk("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
